// File: rtl/prescaled_counter_pkg.sv
// rtl/prescaled_counter_pkg.sv - mode encodings and shared helpers for the prescaled counter
package prescaled_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_UP_SAT    = 2'b10,
    MODE_BOUNCE    = 2'b11
  } mode_e;

  // Prescaler register width; a divide-by-one still keeps a 1-bit register.
  function automatic int unsigned pre_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a one-cycle step strobe every DIV enabled cycles
module tick_gen
  import prescaled_counter_pkg::*;
#(
  parameter int unsigned DIV = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   PW       = pre_width(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Strobe is combinational so the counter steps on the same edge the prescaler wraps.
  assign tick = en & (pre_q == PRE_LAST) & ~rst;

  // Next prescaler value: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// rtl/prescaled_counter.sv - prescaled up/down/saturating/bounce counter with terminal-count pulse
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             dir
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  mode_e            mode_m;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  assign mode_m = mode_e'(mode);

  // Load also restarts the prescaler so a freshly loaded value gets a full period.
  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // Next count, bounce direction and terminal-count flag; load beats a step.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    // Outside bounce the direction register is parked at up, so bounce always starts upward.
    if (mode_m != MODE_BOUNCE) begin
      dir_d = 1'b1;
    end
    if (load) begin
      count_d = load_val;
      dir_d   = 1'b1;
    end else if (tick) begin
      case (mode_m)
        MODE_UP_WRAP: begin
          count_d = count_q + CNT_ONE;
          tc_d    = (count_q == CNT_MAX);
        end
        MODE_DOWN_WRAP: begin
          count_d = count_q - CNT_ONE;
          tc_d    = (count_q == CNT_ZERO);
        end
        MODE_UP_SAT: begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
            tc_d    = (count_q == CNT_MAX - CNT_ONE);
          end
        end
        MODE_BOUNCE: begin
          if (WIDTH == 1) begin
            // A 1-bit bounce is a toggle; every step is a turnaround.
            count_d = ~count_q;
            dir_d   = ~count_q[0];
            tc_d    = 1'b1;
          end else if (dir_q) begin
            if (count_q == CNT_MAX) begin
              count_d = CNT_MAX - CNT_ONE;
              dir_d   = 1'b0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end else begin
            if (count_q == CNT_ZERO) begin
              count_d = CNT_ONE;
              dir_d   = 1'b1;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  // Reported direction follows the mode, only bounce exposes the register.
  always_comb begin
    dir = 1'b1;
    case (mode_m)
      MODE_DOWN_WRAP: dir = 1'b0;
      MODE_BOUNCE:    dir = dir_q;
      default:        dir = 1'b1;
    endcase
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// tb/tb_prescaled_counter.sv - self-checking bench for prescaled_counter across four width/divider builds
module tb_prescaled_counter;

  localparam int NI = 4;
  localparam int WS [NI] = '{4, 4, 3, 1};
  localparam int DS [NI] = '{3, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [3:0] load_val;

  logic [3:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic       cnt_w1;
  logic [3:0] tick_v, tc_v, dir_v;
  int         cnt_v [NI];

  int checks = 0;
  int errors = 0;

  int m_pre [NI];
  int m_cnt [NI];
  int m_dir [NI];
  int m_tc  [NI];

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] mode;
    bit       load;
    bit [3:0] lv;
    int       ecnt;
    int       etc;
    int       edir;
  } vec_t;

  vec_t vec [$];

  always #5 clk = ~clk;

  assign cnt_v[0] = int'(cnt_a);
  assign cnt_v[1] = int'(cnt_b);
  assign cnt_v[2] = int'(cnt_c);
  assign cnt_v[3] = int'(cnt_w1);

  prescaled_counter #(.WIDTH(4), .DIV(3)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(cnt_a), .tick(tick_v[0]), .tc(tc_v[0]), .dir(dir_v[0]));
  prescaled_counter #(.WIDTH(4), .DIV(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .count(cnt_b), .tick(tick_v[1]), .tc(tc_v[1]), .dir(dir_v[1]));
  prescaled_counter #(.WIDTH(3), .DIV(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val[2:0]),
    .count(cnt_c), .tick(tick_v[2]), .tc(tc_v[2]), .dir(dir_v[2]));
  prescaled_counter #(.WIDTH(1), .DIV(2)) u_d (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val[0]),
    .count(cnt_w1), .tick(tick_v[3]), .tc(tc_v[3]), .dir(dir_v[3]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference behaviour of one counter for one clock edge, from the rules in plain integers.
  task automatic model_edge(input int i, input bit r, input bit e, input bit [1:0] m,
                            input bit l, input bit [3:0] v);
    int  mx;
    bit  stp;
    mx = (1 << WS[i]) - 1;
    if (r) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_dir[i] = 1; m_tc[i] = 0;
    end else if (l) begin
      m_cnt[i] = int'(v) & mx; m_pre[i] = 0; m_dir[i] = 1; m_tc[i] = 0;
    end else begin
      stp = e && (m_pre[i] == DS[i] - 1);
      if (e) m_pre[i] = (m_pre[i] + 1) % DS[i];
      m_tc[i] = 0;
      if (m != 2'd3) m_dir[i] = 1;
      if (stp) begin
        case (m)
          2'd0: begin m_cnt[i] = (m_cnt[i] + 1) % (mx + 1); m_tc[i] = (m_cnt[i] == 0); end
          2'd1: begin m_cnt[i] = (m_cnt[i] + mx) % (mx + 1); m_tc[i] = (m_cnt[i] == mx); end
          2'd2: if (m_cnt[i] < mx) begin m_cnt[i]++; m_tc[i] = (m_cnt[i] == mx); end
          default: begin
            if (mx == 1) begin
              m_cnt[i] = 1 - m_cnt[i]; m_dir[i] = m_cnt[i]; m_tc[i] = 1;
            end else if (m_dir[i] == 1) begin
              if (m_cnt[i] == mx) begin m_cnt[i] = mx - 1; m_dir[i] = 0; m_tc[i] = 1; end
              else m_cnt[i]++;
            end else begin
              if (m_cnt[i] == 0) begin m_cnt[i] = 1; m_dir[i] = 1; m_tc[i] = 1; end
              else m_cnt[i]--;
            end
          end
        endcase
      end
    end
  endtask

  // Drive one cycle of inputs, check tick before the edge, then check all state after it.
  task automatic apply(input bit r, input bit e, input bit [1:0] m, input bit l, input bit [3:0] v);
    int edir;
    rst = r; en = e; mode = m; load = l; load_val = v;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("tick[%0d]", i), int'(tick_v[i]), int'(!r && e && (m_pre[i] == DS[i] - 1)));
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i, r, e, m, l, v);
    #1;
    for (int i = 0; i < NI; i++) begin
      edir = (m == 2'd1) ? 0 : (m == 2'd3) ? m_dir[i] : 1;
      chk($sformatf("count[%0d]", i), cnt_v[i], m_cnt[i]);
      chk($sformatf("tc[%0d]", i), int'(tc_v[i]), m_tc[i]);
      chk($sformatf("dir[%0d]", i), int'(dir_v[i]), edir);
    end
  endtask

  initial begin
    bit       r, e, l;
    bit [1:0] m;
    bit [3:0] v;
    int       bseq [15];
    rst = 1'b1; en = 1'b0; mode = 2'd0; load = 1'b0; load_val = 4'd0;
    for (int i = 0; i < NI; i++) begin m_pre[i] = 0; m_cnt[i] = 0; m_dir[i] = 1; m_tc[i] = 0; end
    @(posedge clk);
    #1;

    // Hand-computed vectors for the WIDTH=4, DIV=1 build.
    vec.push_back('{1, 1, 2'd1, 0, 4'd0,  0, 0, 0});
    vec.push_back('{0, 1, 2'd1, 0, 4'd0, 15, 1, 0});
    vec.push_back('{0, 1, 2'd1, 0, 4'd0, 14, 0, 0});
    vec.push_back('{0, 1, 2'd1, 0, 4'd0, 13, 0, 0});
    vec.push_back('{0, 1, 2'd1, 1, 4'd5,  5, 0, 0});
    vec.push_back('{0, 1, 2'd0, 0, 4'd0,  6, 0, 1});
    vec.push_back('{0, 0, 2'd0, 0, 4'd0,  6, 0, 1});
    vec.push_back('{0, 0, 2'd0, 1, 4'd15, 15, 0, 1});
    vec.push_back('{0, 1, 2'd0, 0, 4'd0,  0, 1, 1});
    vec.push_back('{0, 1, 2'd2, 0, 4'd0,  1, 0, 1});
    vec.push_back('{0, 1, 2'd2, 1, 4'd14, 14, 0, 1});
    vec.push_back('{0, 1, 2'd2, 0, 4'd0, 15, 1, 1});
    vec.push_back('{0, 1, 2'd2, 0, 4'd0, 15, 0, 1});
    vec.push_back('{1, 1, 2'd2, 1, 4'd9,  0, 0, 1});
    vec.push_back('{0, 1, 2'd3, 0, 4'd0,  1, 0, 1});
    vec.push_back('{0, 1, 2'd3, 1, 4'd15, 15, 0, 1});
    vec.push_back('{0, 1, 2'd3, 0, 4'd0, 14, 1, 0});
    vec.push_back('{0, 1, 2'd0, 0, 4'd0, 15, 0, 1});
    vec.push_back('{0, 1, 2'd3, 0, 4'd0, 14, 1, 0});
    for (int k = 0; k < vec.size(); k++) begin
      apply(vec[k].rst, vec[k].en, vec[k].mode, vec[k].load, vec[k].lv);
      chk($sformatf("vec%0d count", k), int'(cnt_b), vec[k].ecnt);
      chk($sformatf("vec%0d tc", k), int'(tc_v[1]), vec[k].etc);
      chk($sformatf("vec%0d dir", k), int'(dir_v[1]), vec[k].edir);
    end

    // WIDTH=4 DIV=3 up-wrap from reset: one step per 3 edges, tc only after 15->0.
    apply(1, 1, 2'd0, 0, 4'd0);
    for (int k = 1; k <= 49; k++) begin
      apply(0, 1, 2'd0, 0, 4'd0);
      if (k == 3)  chk("upwrap first step", int'(cnt_a), 1);
      if (k == 45) begin chk("upwrap at 15", int'(cnt_a), 15); chk("upwrap no tc at 15", int'(tc_v[0]), 0); end
      if (k == 48) begin chk("upwrap wrap", int'(cnt_a), 0); chk("upwrap wrap tc", int'(tc_v[0]), 1); end
      if (k == 49) chk("upwrap tc one cycle", int'(tc_v[0]), 0);
    end

    // Freeze mid-prescale: pre=1 held for 10 cycles, step lands 2 edges after resume.
    apply(1, 1, 2'd0, 0, 4'd0);
    apply(0, 1, 2'd0, 0, 4'd0);
    for (int k = 0; k < 10; k++) apply(0, 0, 2'd0, 0, 4'd0);
    chk("freeze count", int'(cnt_a), 0);
    apply(0, 1, 2'd0, 0, 4'd0);
    chk("resume edge1", int'(cnt_a), 0);
    apply(0, 1, 2'd0, 0, 4'd0);
    chk("resume edge2", int'(cnt_a), 1);

    // WIDTH=3 DIV=1 bounce walk.
    bseq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    apply(1, 1, 2'd3, 0, 4'd0);
    for (int k = 0; k < 15; k++) begin
      apply(0, 1, 2'd3, 0, 4'd0);
      chk($sformatf("bounce%0d count", k), int'(cnt_c), bseq[k]);
      chk($sformatf("bounce%0d tc", k), int'(tc_v[2]), int'(k == 7 || k == 14));
      chk($sformatf("bounce%0d dir", k), int'(dir_v[2]), int'(k < 7 || k == 14));
    end

    // Randomised traffic against the reference model.
    m = 2'd0;
    apply(1, 1, m, 0, 4'd0);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 29) == 0);
      v = 4'($urandom_range(0, 15));
      apply(r, e, m, l, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 1..32.
REQ-002 SHALL have parameter DIV, default 10000000: prescaler period in clk cycles, legal range >= 1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: enables both prescaler and counter; 0 freezes both.
REQ-006 SHALL have port mode, input, 2: 00 UP_WRAP, 01 DOWN_WRAP, 10 UP_SAT, 11 BOUNCE.
REQ-007 SHALL have port load, input, 1: synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH: value loaded into count.
REQ-009 SHALL have port count, output, WIDTH: registered counter value, suitable for driving LEDs directly.
REQ-010 SHALL have port tick, output, 1: prescaler step strobe.
REQ-011 SHALL have port tc, output, 1: registered terminal-count pulse.
REQ-012 SHALL have port dir, output, 1: current count direction, 1 = up.

Function
REQ-013 Prescaler: SHALL be a register pre, width max(1, clog2(DIV)), counting 0..DIV-1 while en=1, wrapping DIV-1 -> 0; it SHALL hold while en=0.
REQ-014 tick SHALL be combinational: tick = en & (pre == DIV-1) & ~rst. With DIV=1, tick = en & ~rst.
REQ-015 Count step: count SHALL update only on an edge where tick=1, giving a latency of DIV cycles per step (DIV=4, en held 1 after reset: count=1 after the 4th edge).
REQ-016 Priority SHALL be rst > load > step.
REQ-017 load=1: count <= load_val, pre <= 0, dir register <= 1, tc <= 0; load SHALL be accepted regardless of en.
REQ-018 UP_WRAP: count+1; MAX (2^WIDTH-1) -> 0 on a step, and that step SHALL raise tc.
REQ-019 DOWN_WRAP: count-1; 0 -> MAX on a step, and that step SHALL raise tc.
REQ-020 UP_SAT: count+1 up to MAX, then hold at MAX; tc SHALL pulse only on the step entering MAX, never while holding.
REQ-021 BOUNCE, dir=1: count+1; at MAX the step SHALL go to MAX-1, set dir=0 and raise tc.
REQ-022 BOUNCE, dir=0: count-1; at 0 the step SHALL go to 1, set dir=1 and raise tc.
REQ-023 BOUNCE with WIDTH=1: SHALL alternate 0 <-> 1, with tc on every step.
REQ-024 The dir register SHALL be forced to 1 on every edge where mode != BOUNCE, so entering BOUNCE always starts counting up.
REQ-025 dir output SHALL be 1 in UP_WRAP and UP_SAT, 0 in DOWN_WRAP, and the dir register value in BOUNCE.
REQ-026 tc SHALL be registered: high for exactly one cycle, the first cycle count shows the new value; otherwise 0.
REQ-027 A mode change SHALL take effect on the next step and SHALL NOT alter count or pre by itself.
REQ-028 Count arithmetic SHALL be modulo 2^WIDTH; no carry is exported.

Reset
REQ-029 On an edge with rst=1: count <= 0, pre <= 0, dir register <= 1, tc <= 0; tick SHALL be 0 while rst=1.
REQ-030 Reset mid-operation SHALL discard any pending step, with no tc afterwards.
REQ-031 There SHALL be no initial-value dependence; behaviour is defined only after the first rst.

Structure
REQ-032 Package prescaled_counter_pkg SHALL hold the 2-bit mode encodings (MODE_UP_WRAP, MODE_DOWN_WRAP, MODE_UP_SAT, MODE_BOUNCE).
REQ-033 The prescaler SHALL be a sub-module tick_gen (params DIV; ports clk, rst, en, clr, tick), with clr driven by load.
REQ-034 The counter, direction and tc logic SHALL reside in prescaled_counter.

Verification
REQ-035 WIDTH=4, DIV=3, UP_WRAP, en=1 from reset -> tick every 3rd cycle; count 0..15 then 0; tc pulses one cycle after the 15->0 step only.
REQ-036 WIDTH=4, DIV=1, DOWN_WRAP from reset -> count 15 one cycle later with tc=1, then 14, 13, ... each cycle.
REQ-037 WIDTH=4, DIV=2, UP_SAT, load_val=13 -> 14, 15 (tc once), then 15 held, no further tc.
REQ-038 WIDTH=3, DIV=1, BOUNCE -> 0,1,..,7,6,..,0,1; dir flips at 7 and 0; tc on the steps to 6 and to 1.
REQ-039 en=0 for 10 cycles mid-prescale (pre=1, DIV=3) -> count and pre frozen; the step resumes 2 cycles after en=1.
REQ-040 load and tick on the same edge -> count=load_val, pre=0, no step; rst with load -> count=0.
